// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud timing derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; a push into a full FIFO is taken only alongside a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_pop  = pop & !empty;
        do_push = push & (!full | do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 serial receiver with valid/ready byte output and framing/overflow pulses.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 rx_busy,
    output logic                 framing_error,
    output logic                 overflow
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_TIME - 1);

    if (SYMBOL_EDGE_TIME < 4) begin : g_bad_baud
        $error("uart_rx_deframer: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_deframer: FIFO_DEPTH must be a power of 2");
    end

    // state    | meaning
    // RX_IDLE  | waiting for a falling edge on an armed line
    // RX_START | confirming the start bit at its midpoint
    // RX_DATA  | sampling 8 data bits, LSB first, one per symbol
    // RX_STOP  | sampling the stop bit, then back to idle
    rx_state_e state_q, state_d;

    logic                 sync1_q, sync1_d, rx_s_q, rx_s_d;
    logic [1:0]           fill_q, fill_d;
    logic                 armed_q, armed_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 framing_error_q, framing_error_d;
    logic                 overflow_q, overflow_d;
    logic                 stop_hit, byte_ok, accept, buf_full, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (armed_q && !rx_s_q) state_d = RX_START;
            RX_START: if (cnt_q == CNT_MID) state_d = rx_s_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == CNT_LAST && idx_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
            RX_STOP:  if (cnt_q == CNT_LAST) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Arming waits until the synchroniser has flushed its reset preset, so only a real idle line counts.
    always_comb begin
        sync1_d = serial_in;
        rx_s_d  = sync1_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & rx_s_q);
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            RX_START: if (cnt_q == CNT_MID) begin
                cnt_d = '0;
                idx_d = '0;
            end
            RX_DATA: if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                idx_d   = idx_q + 3'd1;
                shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            end
            RX_STOP: if (cnt_q == CNT_LAST) cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        rx_busy         = (state_q != RX_IDLE);
        stop_hit        = (state_q == RX_STOP) && (cnt_q == CNT_LAST);
        byte_ok         = stop_hit & rx_s_q;
        framing_error_d = stop_hit & !rx_s_q;
        accept          = byte_ok & (!buf_full | pop);
        overflow_d      = byte_ok & !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 1'b1;
            rx_s_q          <= 1'b1;
            fill_q          <= '0;
            armed_q         <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            rx_s_q          <= rx_s_d;
            fill_q          <= fill_d;
            armed_q         <= armed_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            framing_error_q <= framing_error_d;
            overflow_q      <= overflow_d;
        end
    end

    assign framing_error = framing_error_q;
    assign overflow      = overflow_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_full, fifo_empty;

    assign buf_full       = fifo_full;
    assign pop            = !fifo_empty & data_out_ready;
    assign data_out_valid = !fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (data_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

    assign buf_full       = hold_valid_q;
    assign pop            = hold_valid_q & data_out_ready;
    assign data_out_valid = hold_valid_q;
    assign data_out       = hold_data_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = shift_q;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
`endif

endmodule
